// File: rtl/nmk_oki_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : nmk_oki_rom_fetch
// Brief    : Two-channel OKI sample-ROM byte fetcher. Edge-detects per-channel
//            byte requests, arbitrates round-robin onto one external ROM port
//            and keeps a one-entry last-byte cache per channel.
// Revision : 1.0 - initial release
// ============================================================================
module nmk_oki_rom_fetch #(
  parameter logic [21:0] ROM_OFFSET = 22'h000000,
  parameter int          HIT_EN     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        OKI1_REQ,
  input  logic [17:0] OKI1_A,
  input  logic [5:0]  OKI1_BANK,
  output logic        OKI1_ACK,
  output logic [7:0]  OKI1_DATA,
  input  logic        OKI2_REQ,
  input  logic [17:0] OKI2_A,
  input  logic [5:0]  OKI2_BANK,
  output logic        OKI2_ACK,
  output logic [7:0]  OKI2_DATA,
  output logic        ROM_REQ,
  output logic [21:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [7:0]  ROM_DATA
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Index 0 is OKI1, index 1 is OKI2 throughout.
  logic [1:0]  w_req;
  logic [1:0]  w_rise;
  logic [1:0]  w_load;
  logic [1:0]  w_done;
  logic [21:0] w_addr_new [2];
  logic        w_pick;
  logic        w_hit;
  logic        w_unused;

  logic [1:0]  r_prev;
  logic [1:0]  r_pend;
  logic [1:0]  r_ack;
  logic [1:0]  r_cv;
  logic [21:0] r_addr [2];
  logic [21:0] r_ca [2];
  logic [7:0]  r_cd [2];
  logic [7:0]  r_data [2];
  logic        r_sel;
  logic        r_last;
  logic        r_rom_req;
  logic [21:0] r_rom_addr;

  assign w_req  = {OKI2_REQ, OKI1_REQ};
  assign w_rise = w_req & ~r_prev;
  // A rising edge only latches on a channel that is not already pending.
  assign w_load = w_rise & ~r_pend;

  // The sample address is {bank, A[15:0]}; the 22-bit sum drops any carry.
  assign w_addr_new[0] = {OKI1_BANK, OKI1_A[15:0]} + ROM_OFFSET;
  assign w_addr_new[1] = {OKI2_BANK, OKI2_A[15:0]} + ROM_OFFSET;

  // The top two sample address bits are superseded by the bank value.
  assign w_unused = ^{OKI1_A[17:16], OKI2_A[17:16]};

  assign w_hit = (HIT_EN != 0) && r_cv[r_sel] && (r_ca[r_sel] == r_addr[r_sel]);

  assign OKI1_ACK  = r_ack[0];
  assign OKI2_ACK  = r_ack[1];
  assign OKI1_DATA = r_data[0];
  assign OKI2_DATA = r_data[1];
  assign ROM_REQ   = r_rom_req;
  assign ROM_ADDR  = r_rom_addr;

  // Arbiter state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbiter next state, channel pick and per-channel completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_pick      = r_sel;
    w_done      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 2'b00) begin
          w_state_nxt = S_ISSUE;
          if (r_pend == 2'b11) begin
            w_pick = ~r_last;
          end else begin
            w_pick = r_pend[1];
          end
        end
      end
      S_ISSUE: begin
        if (w_hit) begin
          w_state_nxt   = S_IDLE;
          w_done[r_sel] = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ROM_ACK) begin
          w_state_nxt   = S_IDLE;
          w_done[r_sel] = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture, ROM handshake, cache and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev     <= 2'b00;
      r_pend     <= 2'b00;
      r_ack      <= 2'b00;
      r_cv       <= 2'b00;
      r_addr[0]  <= '0;
      r_addr[1]  <= '0;
      r_ca[0]    <= '0;
      r_ca[1]    <= '0;
      r_cd[0]    <= '0;
      r_cd[1]    <= '0;
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_sel      <= 1'b0;
      r_last     <= 1'b1;
      r_rom_req  <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_prev <= w_req;
      r_ack  <= w_done;
      r_pend <= (r_pend & ~w_done) | w_load;
      if (w_load[0]) begin
        r_addr[0] <= w_addr_new[0];
      end
      if (w_load[1]) begin
        r_addr[1] <= w_addr_new[1];
      end
      if ((r_state == S_IDLE) && (r_pend != 2'b00)) begin
        r_sel  <= w_pick;
        r_last <= w_pick;
      end
      if (r_state == S_ISSUE) begin
        if (w_hit) begin
          r_data[r_sel] <= r_cd[r_sel];
        end else begin
          r_rom_req  <= 1'b1;
          r_rom_addr <= r_addr[r_sel];
        end
      end
      if ((r_state == S_WAIT) && ROM_ACK) begin
        r_data[r_sel] <= ROM_DATA;
        r_cv[r_sel]   <= 1'b1;
        r_ca[r_sel]   <= r_addr[r_sel];
        r_cd[r_sel]   <= ROM_DATA;
        r_rom_req     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
